// File: rtl/int_sequencer.sv
// int_sequencer: multi-cycle controller for interrupt entry and return-from-interrupt.
// On entry it drains the pipeline, pushes the 32-bit return PC as two 16-bit
// stack words (high word first), then vectors to INT_VECTOR. On RTI it pops
// the low word, then the high word, and resumes at the reassembled PC.
//
// Stack handshake: push_en / pop_en act as "valid" and are held steady, with
// stable push_data, until mem_ready is high. A word transfers in exactly the
// cycle where the enable and mem_ready are both high; pop_data is captured in
// that same cycle.
module int_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        ret_req,
    input  logic [31:0] pc_current,
    input  logic        mem_ready,
    input  logic [15:0] pop_data,
    output logic        stall_fetch,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        push_en,
    output logic [15:0] push_data,
    output logic        pop_en,
    output logic [1:0]  mem_state,
    output logic        pc_load,
    output logic [31:0] pc_load_val,
    output logic        int_active,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        PUSH_HI = 3'd2,
        PUSH_LO = 3'd3,
        VECTOR  = 3'd4,
        POP_LO  = 3'd5,
        POP_HI  = 3'd6,
        RESUME  = 3'd7
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        pending;
    logic [31:0] saved_pc;
    logic [31:0] ret_pc;
    logic [3:0]  drain_cnt;
    logic        start_rti;
    logic        start_int;

    // RTI has priority over a pending interrupt when both are seen in IDLE.
    assign start_rti = (state == IDLE) && ret_req && int_active;
    assign start_int = (state == IDLE) && !start_rti && pending && !int_active;

    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_rti) begin
                    state_next = POP_LO;
                end else if (start_int) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   if (drain_cnt == 4'd0) state_next = PUSH_HI;
            PUSH_HI: if (mem_ready) state_next = PUSH_LO;
            PUSH_LO: if (mem_ready) state_next = VECTOR;
            VECTOR:  state_next = IDLE;
            POP_LO:  if (mem_ready) state_next = POP_HI;
            POP_HI:  if (mem_ready) state_next = RESUME;
            RESUME:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore output decode; everything is zero unless the state asserts it.
    always_comb begin
        stall_fetch = 1'b0;
        flush_fd    = 1'b0;
        flush_de    = 1'b0;
        push_en     = 1'b0;
        push_data   = 16'h0000;
        pop_en      = 1'b0;
        mem_state   = 2'b00;
        pc_load     = 1'b0;
        pc_load_val = 32'h0000_0000;
        case (state)
            DRAIN: begin
                stall_fetch = 1'b1;
                flush_fd    = 1'b1;
            end
            PUSH_HI: begin
                stall_fetch = 1'b1;
                push_en     = 1'b1;
                mem_state   = 2'b01;
                push_data   = saved_pc[31:16];
            end
            PUSH_LO: begin
                stall_fetch = 1'b1;
                push_en     = 1'b1;
                mem_state   = 2'b01;
                push_data   = saved_pc[15:0];
            end
            VECTOR: begin
                pc_load     = 1'b1;
                pc_load_val = INT_VECTOR;
                flush_de    = 1'b1;
            end
            POP_LO, POP_HI: begin
                stall_fetch = 1'b1;
                pop_en      = 1'b1;
                mem_state   = 2'b10;
            end
            RESUME: begin
                pc_load     = 1'b1;
                pc_load_val = ret_pc;
                flush_fd    = 1'b1;
                flush_de    = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequence datapath: pending latch, handler flag, drain counter, PC words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= 1'b0;
            int_active <= 1'b0;
            saved_pc   <= 32'h0000_0000;
            ret_pc     <= 32'h0000_0000;
            drain_cnt  <= 4'd0;
        end else begin
            // A request arriving in the VECTOR cycle itself is kept, not lost.
            pending <= int_req || (pending && (state != VECTOR));

            if (state == VECTOR) begin
                int_active <= 1'b1;
            end else if (state == RESUME) begin
                int_active <= 1'b0;
            end

            if (start_int) begin
                saved_pc  <= pc_current;
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == DRAIN) && (drain_cnt != 4'd0)) begin
                drain_cnt <= drain_cnt - 4'd1;
            end

            if ((state == POP_LO) && mem_ready) begin
                ret_pc[15:0] <= pop_data;
            end
            if ((state == POP_HI) && mem_ready) begin
                ret_pc[31:16] <= pop_data;
            end
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer. Scenarios (interrupt entry, RTI,
// ignored RTI, reset abort) are expanded into per-cycle records of expected
// outputs plus the inputs to drive in that cycle; records are replayed and
// compared on the falling edge.
module tb_int_sequencer;

  localparam int          D   = 3;
  localparam logic [31:0] VEC = 32'h0000_0000;
  localparam int          W   = 60;

  logic        clk;
  logic        reset;
  logic        int_req;
  logic        ret_req;
  logic [31:0] pc_current;
  logic        mem_ready;
  logic [15:0] pop_data;
  logic        stall_fetch;
  logic        flush_fd;
  logic        flush_de;
  logic        push_en;
  logic [15:0] push_data;
  logic        pop_en;
  logic [1:0]  mem_state;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        int_active;
  logic [2:0]  state_dbg;

  typedef struct packed {
    logic        int_req;
    logic        ret_req;
    logic [31:0] pc;
    logic        mem_ready;
    logic [15:0] pop_data;
  } drv_t;

  logic [W-1:0] exp_q[$];
  drv_t         drv_q[$];
  string        tag_q[$];

  int n_vec;
  int n_err;
  bit m_active;
  bit m_pending;

  int_sequencer #(.DRAIN_CYCLES(D), .INT_VECTOR(VEC)) dut (
    .clk        (clk),
    .reset      (reset),
    .int_req    (int_req),
    .ret_req    (ret_req),
    .pc_current (pc_current),
    .mem_ready  (mem_ready),
    .pop_data   (pop_data),
    .stall_fetch(stall_fetch),
    .flush_fd   (flush_fd),
    .flush_de   (flush_de),
    .push_en    (push_en),
    .push_data  (push_data),
    .pop_en     (pop_en),
    .mem_state  (mem_state),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .int_active (int_active),
    .state_dbg  (state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ev(logic st, logic ffd, logic fde, logic pe,
                                      logic [15:0] pd, logic po, logic [1:0] ms,
                                      logic pl, logic [31:0] pv, logic ia,
                                      logic [2:0] s);
    return {st, ffd, fde, pe, pd, po, ms, pl, pv, ia, s};
  endfunction

  function automatic logic [W-1:0] ev_idle(logic ia);
    return ev(0, 0, 0, 0, 16'h0, 0, 2'b00, 0, 32'h0, ia, 3'd0);
  endfunction

  function automatic logic [W-1:0] observed();
    return {stall_fetch, flush_fd, flush_de, push_en, push_data, pop_en,
            mem_state, pc_load, pc_load_val, int_active, state_dbg};
  endfunction

  function automatic drv_t rnd_drv();
    drv_t d;
    d.int_req   = 1'b0;
    d.ret_req   = 1'b0;
    d.pc        = $urandom;
    d.mem_ready = 1'($urandom_range(0, 1));
    d.pop_data  = 16'($urandom);
    return d;
  endfunction

  function automatic logic coin(bit noise);
    return noise && ($urandom_range(0, 7) == 0);
  endfunction

  task automatic check_val(string tag, logic [W-1:0] got, logic [W-1:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // One record; pending follows: any int_req sets it, only VECTOR clears it.
  task automatic add(string tag, logic [W-1:0] e, drv_t d, bit is_vector);
    exp_q.push_back(e);
    drv_q.push_back(d);
    tag_q.push_back(tag);
    m_pending = d.int_req || (m_pending && !is_vector);
  endtask

  task automatic gen_entry(bit pulse, bit hold, bit noise, logic [31:0] p,
                           int w_hi, int w_lo);
    drv_t d;
    if (pulse) begin
      d = rnd_drv();
      d.int_req = 1'b1;
      add("int_pulse", ev_idle(0), d, 0);
    end
    d = rnd_drv();
    d.pc = p;
    d.int_req = hold | coin(noise);
    add("decide", ev_idle(0), d, 0);
    for (int i = 0; i < D; i++) begin
      d = rnd_drv();
      d.int_req = hold | coin(noise);
      d.ret_req = coin(noise);
      add("drain", ev(1, 1, 0, 0, 16'h0, 0, 2'b00, 0, 32'h0, 0, 3'd1), d, 0);
    end
    for (int i = 0; i <= w_hi; i++) begin
      d = rnd_drv();
      d.mem_ready = (i == w_hi);
      d.int_req = hold | coin(noise);
      d.ret_req = coin(noise);
      add("push_hi", ev(1, 0, 0, 1, p[31:16], 0, 2'b01, 0, 32'h0, 0, 3'd2), d, 0);
    end
    for (int i = 0; i <= w_lo; i++) begin
      d = rnd_drv();
      d.mem_ready = (i == w_lo);
      d.int_req = hold | coin(noise);
      d.ret_req = coin(noise);
      add("push_lo", ev(1, 0, 0, 1, p[15:0], 0, 2'b01, 0, 32'h0, 0, 3'd3), d, 0);
    end
    d = rnd_drv();
    d.int_req = hold | coin(noise);
    d.ret_req = coin(noise);
    add("vector", ev(0, 0, 1, 0, 16'h0, 0, 2'b00, 1, VEC, 0, 3'd4), d, 1);
    m_active = 1'b1;
  endtask

  task automatic gen_rti(bit hold, bit noise, logic [31:0] r, int w_lo, int w_hi);
    drv_t d;
    d = rnd_drv();
    d.ret_req = 1'b1;
    d.int_req = hold | coin(noise);
    add("rti_req", ev_idle(1), d, 0);
    for (int i = 0; i <= w_lo; i++) begin
      d = rnd_drv();
      d.mem_ready = (i == w_lo);
      if (i == w_lo) d.pop_data = r[15:0];
      d.int_req = hold | coin(noise);
      d.ret_req = coin(noise);
      add("pop_lo", ev(1, 0, 0, 0, 16'h0, 1, 2'b10, 0, 32'h0, 1, 3'd5), d, 0);
    end
    for (int i = 0; i <= w_hi; i++) begin
      d = rnd_drv();
      d.mem_ready = (i == w_hi);
      if (i == w_hi) d.pop_data = r[31:16];
      d.int_req = hold | coin(noise);
      d.ret_req = coin(noise);
      add("pop_hi", ev(1, 0, 0, 0, 16'h0, 1, 2'b10, 0, 32'h0, 1, 3'd6), d, 0);
    end
    d = rnd_drv();
    d.int_req = hold | coin(noise);
    d.ret_req = coin(noise);
    add("resume", ev(0, 1, 1, 0, 16'h0, 0, 2'b00, 1, r, 1, 3'd7), d, 0);
    m_active = 1'b0;
  endtask

  task automatic gen_ret_ignored();
    drv_t d;
    d = rnd_drv();
    d.ret_req = 1'b1;
    add("ret_ignored", ev_idle(0), d, 0);
  endtask

  task automatic gen_quiet(int n);
    drv_t d;
    for (int i = 0; i < n; i++) begin
      d = rnd_drv();
      d.mem_ready = 1'b1;
      add("quiet", ev_idle(m_active), d, 0);
    end
  endtask

  // driver: compare this cycle's outputs, then drive this cycle's inputs
  task automatic run_one();
    drv_t d;
    @(negedge clk);
    check_val(tag_q.pop_front(), observed(), exp_q.pop_front());
    d = drv_q.pop_front();
    int_req    = d.int_req;
    ret_req    = d.ret_req;
    pc_current = d.pc;
    mem_ready  = d.mem_ready;
    pop_data   = d.pop_data;
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) run_one();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    m_active   = 1'b0;
    m_pending  = 1'b0;
    reset      = 1'b0;
    int_req    = 1'b0;
    ret_req    = 1'b0;
    pc_current = 32'h0;
    mem_ready  = 1'b0;
    pop_data   = 16'h0;

    // reset state
    repeat (2) @(negedge clk);
    check_val("reset", observed(), ev_idle(0));
    reset = 1'b1;

    // reset asserted in the middle of PUSH_LO aborts the sequence
    gen_entry(1, 0, 0, 32'hCAFE_F00D, 0, 4);
    for (int i = 0; i < D + 4; i++) run_one();
    #2 reset = 1'b0;
    #1 check_val("rst_async", observed(), ev_idle(0));
    exp_q.delete();
    drv_q.delete();
    tag_q.delete();
    m_active  = 1'b0;
    m_pending = 1'b0;
    @(negedge clk);
    int_req   = 1'b0;
    ret_req   = 1'b0;
    mem_ready = 1'b1;
    reset     = 1'b1;
    gen_quiet(4);
    run_all();

    // basic entry, then basic RTI restoring the same PC
    gen_entry(1, 0, 0, 32'h0001_2345, 0, 0);
    run_all();
    gen_rti(0, 0, 32'h0001_2345, 0, 0);
    run_all();

    // memory holds off the high push for 4 cycles
    gen_entry(1, 0, 0, $urandom, 4, 0);
    run_all();
    gen_rti(0, 0, $urandom, 1, 2);
    run_all();

    // RTI outside a handler is ignored
    gen_ret_ignored();
    gen_quiet(2);
    run_all();

    // int_req held through a handler; RTI wins, then re-entry right after
    gen_entry(1, 1, 0, $urandom, 0, 0);
    gen_quiet(2);
    gen_rti(1, 0, $urandom, 0, 0);
    gen_entry(0, 0, 0, $urandom, 0, 0);
    gen_rti(0, 0, $urandom, 0, 0);
    run_all();

    // randomized sequences with noisy requests and memory back-pressure
    for (int it = 0; it < 40; it++) begin
      if (m_active) begin
        gen_rti($urandom_range(0, 3) == 0, 1, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (m_pending) begin
        gen_entry(0, $urandom_range(0, 3) == 0, 1, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        gen_ret_ignored();
      end else begin
        gen_entry(1, 0, 1, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      run_all();
    end

    gen_quiet(1);
    run_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Multi-cycle controller that sequences interrupt entry and return-from-interrupt (RTI) for the 5-stage pipeline.
- Sits beside the hazard detection unit.
- Drives the fetch stall, the FD/DE flushes, the fetch PC-load path, and the memory stage's stack push/pop port.
- Saves and restores the 32-bit PC as two 16-bit stack words.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN letting in-flight instructions retire (legal range 1..15).
- INT_VECTOR, 32'h0000_0000, PC loaded on interrupt entry.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- int_req  in  1  external interrupt line, sampled each cycle.
- ret_req  in  1  one-cycle pulse from execute when an RTI is decoded.
- pc_current  in  32  PC of the next instruction to fetch.
- mem_ready  in  1  memory stage accepts the push/pop this cycle.
- pop_data  in  16  stack word; valid in the cycle pop_en && mem_ready.
- stall_fetch  out  1  freeze fetch PC and FD buffer.
- flush_fd  out  1  clear FD buffer.
- flush_de  out  1  clear DE buffer.
- push_en  out  1  request stack push.
- push_data  out  16  word to push.
- pop_en  out  1  request stack pop.
- mem_state  out  2  memory-stage state: 00 normal, 01 push, 10 pop.
- pc_load  out  1  one-cycle PC override.
- pc_load_val  out  32  PC value for the override.
- int_active  out  1  inside an interrupt handler.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; pending, int_active, saved_pc, ret_pc, drain counter all 0.
  - All outputs 0.
  - Reset mid-sequence aborts it; no partial push/pop is replayed.
- pending:
  - Set on any cycle with int_req=1.
  - Cleared only in VECTOR.
  - Holding int_req high across a handler does not cause re-entry until int_active clears.
- States (3-bit, encoding 0..7): IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, POP_LO, POP_HI, RESUME.
- IDLE:
  - Priority 1: ret_req && int_active -> POP_LO.
  - Priority 2: else pending && !int_active -> DRAIN; latch saved_pc=pc_current; load counter=DRAIN_CYCLES-1.
  - ret_req with int_active=0 is ignored.
  - Simultaneous ret_req and pending: RTI wins; pending is held and serviced on the next IDLE cycle.
- DRAIN:
  - stall_fetch=1, flush_fd=1.
  - Counter decrements each cycle; at 0 -> PUSH_HI.
  - Residency is exactly DRAIN_CYCLES cycles.
- PUSH_HI: stall_fetch=1, push_en=1, mem_state=01, push_data=saved_pc[31:16]; advance to PUSH_LO when mem_ready, else hold.
- PUSH_LO: same outputs with push_data=saved_pc[15:0]; advance to VECTOR on mem_ready.
- VECTOR (1 cycle):
  - pc_load=1, pc_load_val=INT_VECTOR, flush_de=1.
  - Set int_active, clear pending -> IDLE.
- POP_LO: stall_fetch=1, pop_en=1, mem_state=10; on mem_ready capture ret_pc[15:0]=pop_data -> POP_HI.
- POP_HI: same outputs; on mem_ready capture ret_pc[31:16]=pop_data -> RESUME.
- RESUME (1 cycle):
  - pc_load=1, pc_load_val=ret_pc, flush_fd=1, flush_de=1.
  - Clear int_active -> IDLE.
- Rules common to all states:
  - push_en and pop_en are never high together.
  - mem_state=00 whenever neither is high.
  - Outputs are Moore (decoded from state), except the IDLE->DRAIN latch of saved_pc.
  - int_req pulses arriving during any non-IDLE state are latched into pending and never lost.
- Latency with mem_ready tied high:
  - Interrupt entry = DRAIN_CYCLES + 3 cycles from the IDLE decision to the pc_load cycle.
  - RTI = 3 cycles from ret_req to the pc_load cycle.

Test Plan:
1. Reset low mid-PUSH_LO, then release -> all outputs 0 and state IDLE in the same cycle reset falls; no push after release.
2. pc_current=32'h0001_2345, 1-cycle int_req pulse, mem_ready=1, DRAIN_CYCLES=3 -> 3 cycles stall+flush_fd, then push_data 16'h0001 then 16'h2345, then pc_load with 0x0, int_active=1.
3. mem_ready low for 4 cycles during PUSH_HI -> push_en and push_data held stable 5 cycles; PUSH_LO not entered early.
4. ret_req with int_active=1, pop_data 16'h2345 then 16'h0001 -> pc_load_val=32'h0001_2345, flush_fd=flush_de=1 on that cycle, int_active=0.
5. int_req held high through a handler; ret_req and pending in the same IDLE cycle -> RTI completes first, then a new DRAIN begins the cycle after returning to IDLE.
6. ret_req with int_active=0 -> no state change and all outputs stay 0.
